// File: rtl/ula_pkg.sv
// ula_pkg: shared ULA opcodes, widths and EX/MEM register layout for the execute stage.
package ula_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  typedef enum logic [3:0] {
    ULA_ADD  = 4'h0,
    ULA_SUB  = 4'h1,
    ULA_SUB2 = 4'h2,
    ULA_AND  = 4'h3,
    ULA_OR   = 4'h4,
    ULA_XOR  = 4'h5,
    ULA_SLL  = 4'h6,
    ULA_SRL  = 4'h7,
    ULA_SRA  = 4'h8
  } ula_op_t;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ovf;
  } ex_mem_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: operand bypass; EX/MEM result beats WB data, register 0 is never bypassed.
module fwd_mux #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          en,
  input  logic [AW-1:0] src,
  input  logic [W-1:0]  val,
  input  logic          ex_hit,
  input  logic [AW-1:0] ex_rd,
  input  logic [W-1:0]  ex_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [W-1:0]  wb_data,
  output logic [W-1:0]  y
);
  logic live;
  assign live = en && (src != '0);
  assign y = (live && ex_hit && ex_rd == src) ? ex_data :
             (live && wb_we && wb_rd == src) ? wb_data : val;
endmodule

// File: rtl/ula32.sv
// ula32: 32-bit MIPS ALU; codes 1001-1111 yield zero.
module ula32 #(
  parameter int W = 32
) (
  input  logic [3:0]   ULAControl,
  input  logic [W-1:0] scrA,
  input  logic [W-1:0] scrB,
  output logic [W-1:0] ULAResult,
  output logic         Zero
);
  always_comb begin
    ULAResult = '0;
    case (ULAControl)
      4'h0:       ULAResult = scrA + scrB;
      4'h1, 4'h2: ULAResult = scrA - scrB;
      4'h3:       ULAResult = scrA & scrB;
      4'h4:       ULAResult = scrA | scrB;
      4'h5:       ULAResult = scrA ^ scrB;
      4'h6:       ULAResult = scrA << scrB[4:0];
      4'h7:       ULAResult = scrA >> scrB[4:0];
      4'h8:       ULAResult = $signed(scrA) >>> scrB[4:0];
      default:    ULAResult = '0;
    endcase
  end
  assign Zero = (ULAResult == '0);
endmodule

// File: rtl/ula_ex_stage.sv
// ula_ex_stage: MIPS execute stage with forwarding and a valid/ready EX/MEM register.
// Define ULA_OVF_EN to flag signed add/sub overflow and suppress the register write.
module ula_ex_stage #(
  parameter int DATA_W = ula_pkg::DATA_W,
  parameter int REG_AW = ula_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_b_is_reg,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              out_ovf
);
  import ula_pkg::*;
  ex_mem_t ex_q, ex_d;
  logic valid_q, valid_d, acc, zero, ovf;
  logic [DATA_W-1:0] a_fwd, b_fwd, res;
  assign in_ready = !valid_q || out_ready;
  assign acc = in_valid && in_ready;
  fwd_mux #(.W(DATA_W), .AW(REG_AW)) u_fwd_a (
    .en(1'b1), .src(in_rs), .val(in_a), .ex_hit(valid_q && ex_q.we), .ex_rd(ex_q.rd),
    .ex_data(ex_q.result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .y(a_fwd)
  );
  fwd_mux #(.W(DATA_W), .AW(REG_AW)) u_fwd_b (
    .en(in_b_is_reg), .src(in_rt), .val(in_b), .ex_hit(valid_q && ex_q.we), .ex_rd(ex_q.rd),
    .ex_data(ex_q.result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .y(b_fwd)
  );
  ula32 #(.W(DATA_W)) u_ula (
    .ULAControl(in_ctrl), .scrA(a_fwd), .scrB(b_fwd), .ULAResult(res), .Zero(zero)
  );
`ifdef ULA_OVF_EN
  assign ovf = (in_ctrl == ULA_ADD) ?
                 (a_fwd[DATA_W-1] == b_fwd[DATA_W-1] && res[DATA_W-1] != a_fwd[DATA_W-1]) :
               (in_ctrl == ULA_SUB || in_ctrl == ULA_SUB2) ?
                 (a_fwd[DATA_W-1] != b_fwd[DATA_W-1] && res[DATA_W-1] != a_fwd[DATA_W-1]) : 1'b0;
`else
  assign ovf = 1'b0;
`endif
  always_comb begin
    valid_d = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : valid_q;
    ex_d = ex_q;
    if (acc && !flush) ex_d = '{result: res, zero: zero, rd: in_rd, we: in_we && !ovf, ovf: ovf};
    if (flush) ex_d.we = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_result = ex_q.result;
  assign out_zero   = ex_q.zero;
  assign out_rd     = ex_q.rd;
  assign out_we     = ex_q.we;
  assign out_ovf    = ex_q.ovf;
endmodule

// File: tb/tb_ula_ex_stage.sv
// tb_ula_ex_stage: directed self-checking bench for ula_ex_stage.
module tb_ula_ex_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [3:0] in_ctrl = '0;
  logic [31:0] in_a = '0, in_b = '0, wb_data = '0, out_result;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, wb_rd = '0, out_rd;
  logic in_b_is_reg = 1'b0, in_we = 1'b0, wb_we = 1'b0;
  logic out_valid, out_ready = 1'b1, out_zero, out_we, out_ovf;
  int checks = 0, failures = 0;
  ula_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_rs(in_rs), .in_rt(in_rt),
    .in_b_is_reg(in_b_is_reg), .in_rd(in_rd), .in_we(in_we), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_we(out_we), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; in_rd = rd; in_we = 1'b1;
    tick();
  endtask
  initial begin
    #3;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", {27'd0, out_zero, out_we, out_ovf, out_rd == 5'd0, in_ready}, 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h0, 32'd3, 32'd2, 5'd4);
    chk("add_valid", {31'd0, out_valid}, 1);
    chk("add_result", out_result, 32'd5);
    chk("add_zero", {31'd0, out_zero}, 0);
    chk("add_rd_we", {26'd0, out_rd, out_we}, {26'd0, 5'd4, 1'b1});
    issue(4'h1, 32'd4, 32'd5, 5'd4);
    chk("sub_result", out_result, 32'hFFFFFFFF);
    issue(4'h2, 32'd10, 32'd3, 5'd4);
    chk("sub2_result", out_result, 32'd7);
    issue(4'h3, 32'hF0F0, 32'hFF00, 5'd4);
    chk("and_result", out_result, 32'hF000);
    issue(4'h4, 32'hF0F0, 32'hFF00, 5'd4);
    chk("or_result", out_result, 32'hFFF0);
    issue(4'h5, 32'hF0F0, 32'hFF00, 5'd4);
    chk("xor_result", out_result, 32'h0FF0);
    issue(4'h6, 32'hC0000004, 32'd4, 5'd4);
    chk("sll_result", out_result, 32'h00000040);
    issue(4'h7, 32'hC0000004, 32'd4, 5'd4);
    chk("srl_result", out_result, 32'h0C000000);
    issue(4'h8, 32'hC0000004, 32'd4, 5'd4);
    chk("sra_result", out_result, 32'hFC000000);
    issue(4'h9, 32'hC0000004, 32'd4, 5'd4);
    chk("nop9_result", out_result, 32'd0);
    chk("nop9_zero", {31'd0, out_zero}, 1);
    issue(4'hF, 32'd1, 32'd1, 5'd4);
    chk("nopF_result", out_result, 32'd0);
    issue(4'h0, 32'd4, 32'd5, 5'd3);
    chk("fwd_setup", out_result, 32'd9);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
    in_rs = 5'd3;
    issue(4'h0, 32'd100, 32'd0, 5'd5);
    chk("fwd_ex_over_wb", out_result, 32'd9);
    issue(4'h0, 32'd100, 32'd0, 5'd5);
    chk("fwd_wb", out_result, 32'd7);
    in_rs = 5'd0;
    wb_rd = 5'd0;
    issue(4'h0, 32'd100, 32'd0, 5'd5);
    chk("fwd_r0_none", out_result, 32'd100);
    wb_rd = 5'd3; in_rt = 5'd3; in_b_is_reg = 1'b1;
    issue(4'h0, 32'd1, 32'd50, 5'd6);
    chk("fwd_b_wb", out_result, 32'd8);
    in_b_is_reg = 1'b0;
    issue(4'h0, 32'd1, 32'd50, 5'd6);
    chk("fwd_b_imm", out_result, 32'd51);
    wb_we = 1'b0; in_rt = 5'd0;
    issue(4'h0, 32'd10, 32'd20, 5'd6);
    out_ready = 1'b0;
    in_a = 32'd1; in_b = 32'd1; in_rd = 5'd7;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", {out_result[26:0], out_valid, out_rd}, {27'd30, 1'b1, 5'd6});
      chk("bp_in_ready_hold", {31'd0, in_ready}, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 1);
    tick();
    chk("bp_drain_load", {out_result[26:0], out_valid, out_rd}, {27'd2, 1'b1, 5'd7});
    in_valid = 1'b0;
    tick();
    chk("drain_empty", {out_result[30:0], out_valid}, {31'd2, 1'b0});
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 1);
    issue(4'h0, 32'd5, 32'd5, 5'd8);
    chk("flush_kill", {out_result[29:0], out_valid, out_we}, {30'd2, 1'b0, 1'b0});
    flush = 1'b0;
    issue(4'h0, 32'd6, 32'd6, 5'd9);
    chk("post_flush", {out_result[29:0], out_valid, out_we}, {30'd12, 1'b1, 1'b1});
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {out_result[26:0], out_valid, out_zero, out_we, out_ovf, out_rd == 5'd0}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'h0, 32'h7FFFFFFF, 32'd1, 5'd10);
    chk("ovf_result", out_result, 32'h80000000);
`ifdef ULA_OVF_EN
    chk("ovf_flag_we", {30'd0, out_ovf, out_we}, 32'h2);
`else
    chk("ovf_flag_we", {30'd0, out_ovf, out_we}, 32'h1);
`endif
    in_valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
